uart_apb_regs: RTL and testbench

- APB3 slave register front-end that sits directly upstream of the uart top level.
- Bus writes push bytes into the TX FIFO; bus reads pop bytes from the RX FIFO.
- Exposes FIFO status and generates one level interrupt from threshold, RX-idle-timeout and error sources.
- Zero-wait-state slave, single clock domain.

---
 rtl/uart_pkg.sv | 56 +++++
 rtl/uart_rx_timeout.sv | 48 ++++
 rtl/uart_apb_regs.sv | 171 +++++++++++++++++
 tb/tb_uart_apb_regs.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================
// uart_pkg : register map, bit indices and CTRL layout shared by the uart APB front-end
// Rev 1.0
// ============================================================
`default_nettype none

package uart_pkg;

  // Byte offsets of the mapped registers
  localparam logic [4:0] UART_REG_DATA     = 5'h00;
  localparam logic [4:0] UART_REG_STATUS   = 5'h04;
  localparam logic [4:0] UART_REG_CTRL     = 5'h08;
  localparam logic [4:0] UART_REG_INT_STAT = 5'h0C;
  localparam logic [4:0] UART_REG_TIMEOUT  = 5'h10;

  localparam int UART_CTRL_IE_RXTHR = 0;
  localparam int UART_CTRL_IE_TXTHR = 1;
  localparam int UART_CTRL_IE_RXTO  = 2;
  localparam int UART_CTRL_IE_ERR   = 3;

  localparam int UART_INT_RXTHR  = 0;
  localparam int UART_INT_TXTHR  = 1;
  localparam int UART_INT_RXTO   = 2;
  localparam int UART_INT_TX_OVF = 3;
  localparam int UART_INT_RX_UNF = 4;
  localparam int UART_INT_W      = 5;

  typedef struct packed {
    logic [7:0] tx_thr;
    logic [7:0] rx_thr;
    logic       ie_err;
    logic       ie_rxto;
    logic       ie_txthr;
    logic       ie_rxthr;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_fields(input logic [3:0] ie,
                                             input logic [7:0] rx_thr,
                                             input logic [7:0] tx_thr);
    ctrl_t c;
    c.ie_rxthr = ie[UART_CTRL_IE_RXTHR];
    c.ie_txthr = ie[UART_CTRL_IE_TXTHR];
    c.ie_rxto  = ie[UART_CTRL_IE_RXTO];
    c.ie_err   = ie[UART_CTRL_IE_ERR];
    c.rx_thr   = rx_thr;
    c.tx_thr   = tx_thr;
    return c;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {8'h00, c.tx_thr, c.rx_thr, 4'h0, c.ie_err, c.ie_rxto, c.ie_txthr, c.ie_rxthr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_timeout.sv
// ============================================================
// uart_rx_timeout : RX idle counter, raises a one-cycle RXTO set pulse per idle episode
// Rev 1.0
// ============================================================
`default_nettype none

module uart_rx_timeout #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_rxfifo_cnt,
  input  logic             i_rxfifo_empty,
  input  logic             i_rxfifo_ren,
  input  logic [15:0]      i_timeout,
  input  logic             i_timeout_wr,
  output logic             o_rxto_set
);

  logic [CNT_W-1:0] r_rx_cnt_q;
  logic [15:0]      r_idle_cnt;
  logic             w_clr;
  logic             w_inc;

  // Any FIFO movement, an empty FIFO or a limit change starts a new idle episode
  assign w_clr = (i_rxfifo_cnt != r_rx_cnt_q) | i_rxfifo_ren | i_rxfifo_empty |
                 (i_timeout == 16'd0) | i_timeout_wr;

  assign w_inc      = !w_clr && (r_idle_cnt < i_timeout);
  assign o_rxto_set = w_inc && ((r_idle_cnt + 16'd1) == i_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt_q <= '0;
      r_idle_cnt <= 16'd0;
    end else begin
      r_rx_cnt_q <= i_rxfifo_cnt;
      if (w_clr) begin
        r_idle_cnt <= 16'd0;
      end else if (w_inc) begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_apb_regs.sv
// ============================================================
// uart_apb_regs : zero-wait APB3 register front-end for the uart FIFOs and interrupt
// Rev 1.0
// ============================================================
`default_nettype none

module uart_apb_regs
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_psel,
  input  logic             i_penable,
  input  logic             i_pwrite,
  input  logic [4:0]       i_paddr,
  input  logic [31:0]      i_pwdata,
  output logic [31:0]      o_prdata,
  output logic             o_pready,
  output logic             o_pslverr,
  output logic             o_txfifo_wen,
  output logic [7:0]       o_txfifo_wdata,
  input  logic             i_txfifo_full,
  input  logic [CNT_W-1:0] i_txfifo_cnt,
  output logic             o_rxfifo_ren,
  input  logic             i_rxfifo_empty,
  input  logic [7:0]       i_rxfifo_rdata,
  input  logic [CNT_W-1:0] i_rxfifo_cnt,
  output logic             o_irq
);

  ctrl_t                 r_ctrl;
  logic [15:0]           r_timeout;
  logic                  r_rxto;
  logic                  r_tx_ovf;
  logic                  r_rx_unf;
  logic                  r_irq;

  logic                  w_acc;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [4:0]            w_off;
  logic                  w_mapped;
  logic                  w_data_wr;
  logic                  w_data_rd;
  logic                  w_ctrl_wr;
  logic                  w_int_wr;
  logic                  w_timeout_wr;
  logic                  w_txfifo_wen;
  logic                  w_rxfifo_ren;
  logic                  w_tx_ovf_set;
  logic                  w_rx_unf_set;
  logic                  w_rxto_set;
  logic [2:0]            w_w1c;
  logic [7:0]            w_tx_cnt8;
  logic [7:0]            w_rx_cnt8;
  logic                  w_rxthr_lvl;
  logic                  w_txthr_lvl;
  logic [UART_INT_W-1:0] w_int_stat;
  logic [3:0]            w_ie;
  logic                  w_irq_nxt;
  logic [31:0]           w_rdata;
  logic                  w_unused_bits;

  assign w_acc    = i_psel & i_penable;
  assign w_wr_acc = w_acc & i_pwrite;
  assign w_rd_acc = w_acc & ~i_pwrite;
  assign w_off    = {i_paddr[4:2], 2'b00};
  assign w_mapped = (i_paddr[4:2] <= 3'd4);

  assign w_data_wr    = w_wr_acc && (w_off == UART_REG_DATA);
  assign w_data_rd    = w_rd_acc && (w_off == UART_REG_DATA);
  assign w_ctrl_wr    = w_wr_acc && (w_off == UART_REG_CTRL);
  assign w_int_wr     = w_wr_acc && (w_off == UART_REG_INT_STAT);
  assign w_timeout_wr = w_wr_acc && (w_off == UART_REG_TIMEOUT);

  assign w_txfifo_wen = w_data_wr & ~i_txfifo_full;
  assign w_rxfifo_ren = w_data_rd & ~i_rxfifo_empty;
  assign w_tx_ovf_set = w_data_wr & i_txfifo_full;
  assign w_rx_unf_set = w_data_rd & i_rxfifo_empty;

  // Strobes are held low while reset is asserted so an interrupted transfer has no effect
  assign o_txfifo_wen   = rst_n & w_txfifo_wen;
  assign o_txfifo_wdata = o_txfifo_wen ? i_pwdata[7:0] : 8'h00;
  assign o_rxfifo_ren   = rst_n & w_rxfifo_ren;
  assign o_pslverr      = rst_n & w_acc & ~w_mapped;
  assign o_prdata       = rst_n ? w_rdata : 32'h0;
  assign o_pready       = 1'b1;
  assign o_irq          = r_irq;

  assign w_tx_cnt8 = 8'(i_txfifo_cnt);
  assign w_rx_cnt8 = 8'(i_rxfifo_cnt);

  assign w_rxthr_lvl = (r_ctrl.rx_thr != 8'd0) && (w_rx_cnt8 >= r_ctrl.rx_thr);
  assign w_txthr_lvl = (w_tx_cnt8 <= r_ctrl.tx_thr);

  assign w_int_stat = {r_rx_unf, r_tx_ovf, r_rxto, w_txthr_lvl, w_rxthr_lvl};
  assign w_ie       = {r_ctrl.ie_err, r_ctrl.ie_rxto, r_ctrl.ie_txthr, r_ctrl.ie_rxthr};

  // IE_ERR gates both the overflow and the underflow source
  assign w_irq_nxt = (|(w_int_stat[3:0] & w_ie)) |
                     (w_int_stat[UART_INT_RX_UNF] & r_ctrl.ie_err);

  assign w_w1c = w_int_wr ? i_pwdata[UART_INT_RX_UNF:UART_INT_RXTO] : 3'b000;

  assign w_unused_bits = ^{i_pwdata[31:24], i_paddr[1:0]};

  uart_rx_timeout #(
    .CNT_W (CNT_W)
  ) u_rx_timeout (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rxfifo_cnt   (i_rxfifo_cnt),
    .i_rxfifo_empty (i_rxfifo_empty),
    .i_rxfifo_ren   (w_rxfifo_ren),
    .i_timeout      (r_timeout),
    .i_timeout_wr   (w_timeout_wr),
    .o_rxto_set     (w_rxto_set)
  );

  always_comb begin
    w_rdata = 32'h0;
    if (w_rd_acc) begin
      case (w_off)
        UART_REG_DATA: begin
          if (!i_rxfifo_empty) begin
            w_rdata[7:0] = i_rxfifo_rdata;
          end
        end
        UART_REG_STATUS: begin
          w_rdata[0]     = i_txfifo_full;
          w_rdata[1]     = i_rxfifo_empty;
          w_rdata[15:8]  = w_tx_cnt8;
          w_rdata[23:16] = w_rx_cnt8;
        end
        UART_REG_CTRL:     w_rdata = ctrl_to_word(r_ctrl);
        UART_REG_INT_STAT: w_rdata[UART_INT_W-1:0] = w_int_stat;
        UART_REG_TIMEOUT:  w_rdata[15:0] = r_timeout;
        default:           w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_timeout <= 16'd0;
      r_rxto    <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_ctrl <= ctrl_from_fields(i_pwdata[3:0], i_pwdata[15:8], i_pwdata[23:16]);
      end
      if (w_timeout_wr) begin
        r_timeout <= i_pwdata[15:0];
      end
      // A set in the same cycle as a write-1-to-clear takes priority
      r_rxto   <= (r_rxto   & ~w_w1c[0]) | w_rxto_set;
      r_tx_ovf <= (r_tx_ovf & ~w_w1c[1]) | w_tx_ovf_set;
      r_rx_unf <= (r_rx_unf & ~w_w1c[2]) | w_rx_unf_set;
      r_irq    <= w_irq_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_regs.sv
// ============================================================
// tb_uart_apb_regs : directed self-checking bench for uart_apb_regs
// Rev 1.0
// ============================================================
`default_nettype none

module tb_uart_apb_regs;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        txfifo_wen;
  logic [7:0]  txfifo_wdata;
  logic        txfifo_full;
  logic [3:0]  txfifo_cnt;
  logic        rxfifo_ren;
  logic        rxfifo_empty;
  logic [7:0]  rxfifo_rdata;
  logic [3:0]  rxfifo_cnt;
  logic        irq;

  int n_cmp;
  int n_bad;

  logic [31:0] cap_rdata;
  logic        cap_slverr;
  logic        cap_wen;
  logic [7:0]  cap_wdata;
  logic        cap_ren;
  logic        cap_setup_fx;
  logic        cap_after_fx;

  uart_apb_regs #(
    .FIFO_DEPTH (8),
    .CNT_W      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_psel         (psel),
    .i_penable      (penable),
    .i_pwrite       (pwrite),
    .i_paddr        (paddr),
    .i_pwdata       (pwdata),
    .o_prdata       (prdata),
    .o_pready       (pready),
    .o_pslverr      (pslverr),
    .o_txfifo_wen   (txfifo_wen),
    .o_txfifo_wdata (txfifo_wdata),
    .i_txfifo_full  (txfifo_full),
    .i_txfifo_cnt   (txfifo_cnt),
    .o_rxfifo_ren   (rxfifo_ren),
    .i_rxfifo_empty (rxfifo_empty),
    .i_rxfifo_rdata (rxfifo_rdata),
    .i_rxfifo_cnt   (rxfifo_cnt),
    .o_irq          (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One APB transfer: setup, access, idle; outputs captured mid-cycle in each phase
  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    #1 cap_setup_fx = txfifo_wen | rxfifo_ren | pslverr | (prdata != 32'h0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    cap_rdata  = prdata;
    cap_slverr = pslverr;
    cap_wen    = txfifo_wen;
    cap_wdata  = txfifo_wdata;
    cap_ren    = rxfifo_ren;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1 cap_after_fx = txfifo_wen | rxfifo_ren | pslverr;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hFF;
    txfifo_full = 1'b0; txfifo_cnt = 4'd0;
    rxfifo_empty = 1'b1; rxfifo_rdata = 8'h00; rxfifo_cnt = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (txfifo_wen !== 1'b0 || irq !== 1'b0 || prdata !== 32'h0 || pready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_outputs: wen=%b irq=%b prdata=%h pready=%b, want 0 0 0 1",
               txfifo_wen, irq, prdata, pready);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    apb_xfer(1'b0, 5'h04, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0002 || cap_slverr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: got %h slverr=%b, want 00000002 slverr=0", cap_rdata, cap_slverr);
    end
    apb_xfer(1'b0, 5'h08, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h, want 00000000", cap_rdata);
    end
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0002) begin
      n_bad++;
      $display("FAIL reset_int_stat: got %h, want 00000002", cap_rdata);
    end
    apb_xfer(1'b0, 5'h10, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_timeout: got %h, want 00000000", cap_rdata);
    end
  endtask

  task automatic test_tx;
    int n_wen;
    apb_xfer(1'b1, 5'h00, 32'h0000_00A5);
    n_cmp++;
    if (cap_setup_fx !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_setup_phase: side effect=%b, want 0", cap_setup_fx);
    end
    n_cmp++;
    if (cap_wen !== 1'b1 || cap_wdata !== 8'hA5 || cap_after_fx !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_push: wen=%b wdata=%h after=%b, want 1 a5 0", cap_wen, cap_wdata, cap_after_fx);
    end
    n_wen = 0;
    for (int i = 1; i < 8; i++) begin
      txfifo_cnt = 4'(i);
      apb_xfer(1'b1, 5'h00, 32'(i));
      if (cap_wen === 1'b1 && cap_wdata === 8'(i)) n_wen++;
    end
    n_cmp++;
    if (n_wen !== 7) begin
      n_bad++;
      $display("FAIL tx_fill: pushes=%0d, want 7", n_wen);
    end
    txfifo_cnt = 4'd8; txfifo_full = 1'b1;
    apb_xfer(1'b1, 5'h00, 32'h0000_005A);
    n_cmp++;
    if (cap_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_full_drop: wen=%b, want 0", cap_wen);
    end
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0008) begin
      n_bad++;
      $display("FAIL tx_ovf_set: int_stat=%h, want 00000008", cap_rdata);
    end
    apb_xfer(1'b1, 5'h0C, 32'h0000_0008);
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL tx_ovf_w1c: int_stat=%h, want 00000000", cap_rdata);
    end
    txfifo_cnt = 4'd0; txfifo_full = 1'b0;
  endtask

  task automatic test_rx;
    rxfifo_empty = 1'b0; rxfifo_rdata = 8'h3C; rxfifo_cnt = 4'd1;
    apb_xfer(1'b0, 5'h00, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_003C || cap_ren !== 1'b1 || cap_after_fx !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_pop: prdata=%h ren=%b after=%b, want 0000003c 1 0", cap_rdata, cap_ren, cap_after_fx);
    end
    rxfifo_empty = 1'b1; rxfifo_rdata = 8'h77; rxfifo_cnt = 4'd0;
    apb_xfer(1'b0, 5'h00, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0 || cap_ren !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_empty_read: prdata=%h ren=%b, want 00000000 0", cap_rdata, cap_ren);
    end
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0012) begin
      n_bad++;
      $display("FAIL rx_unf_set: int_stat=%h, want 00000012", cap_rdata);
    end
    apb_xfer(1'b1, 5'h0C, 32'h0000_0010);
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0002) begin
      n_bad++;
      $display("FAIL rx_unf_w1c: int_stat=%h, want 00000002", cap_rdata);
    end
  endtask

  task automatic test_irq_thr;
    rxfifo_empty = 1'b0; rxfifo_cnt = 4'd3;
    apb_xfer(1'b1, 5'h08, 32'h0000_0401);
    rxfifo_cnt = 4'd4;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_thr_early: irq=%b, want 0", irq);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_thr_rise: irq=%b, want 1", irq);
    end
    rxfifo_cnt = 4'd3;
    #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_thr_hold: irq=%b, want 1", irq);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_thr_fall: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_timeout;
    apb_xfer(1'b1, 5'h08, 32'h0000_0004);
    apb_xfer(1'b1, 5'h10, 32'h0000_000A);
    rxfifo_cnt = 4'd2;
    repeat (11) @(negedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rxto_early: irq=%b, want 0", irq);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL rxto_irq: irq=%b, want 1", irq);
    end
    apb_xfer(1'b1, 5'h0C, 32'h0000_0004);
    rxfifo_cnt = 4'd3;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rxto_cleared: irq=%b, want 0", irq);
    end
    rxfifo_cnt = 4'd2;
    repeat (11) @(negedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rxto_restart_early: irq=%b, want 0", irq);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL rxto_restart_irq: irq=%b, want 1", irq);
    end
    apb_xfer(1'b0, 5'h0C, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0006) begin
      n_bad++;
      $display("FAIL rxto_int_stat: int_stat=%h, want 00000006", cap_rdata);
    end
  endtask

  task automatic test_slverr;
    apb_xfer(1'b0, 5'h18, 32'h0);
    n_cmp++;
    if (cap_slverr !== 1'b1 || cap_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL slverr_read: slverr=%b prdata=%h, want 1 00000000", cap_slverr, cap_rdata);
    end
    apb_xfer(1'b1, 5'h18, 32'hFFFF_FFFF);
    n_cmp++;
    if (cap_slverr !== 1'b1 || cap_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL slverr_write: slverr=%b wen=%b, want 1 0", cap_slverr, cap_wen);
    end
    apb_xfer(1'b0, 5'h08, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_0004 || cap_slverr !== 1'b0) begin
      n_bad++;
      $display("FAIL slverr_ctrl_kept: ctrl=%h slverr=%b, want 00000004 0", cap_rdata, cap_slverr);
    end
    apb_xfer(1'b0, 5'h10, 32'h0);
    n_cmp++;
    if (cap_rdata !== 32'h0000_000A) begin
      n_bad++;
      $display("FAIL slverr_timeout_kept: timeout=%h, want 0000000a", cap_rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_tx();
    test_rx();
    test_irq_thr();
    test_timeout();
    test_slverr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
